// File: rtl/tt_vec_pkg.sv
// Shared types and vector-layout constants for the TinyTapeout vector player.
// TT_VEC_UIO_CHECK_EN widens each vector to carry uio expect/mask fields.
package tt_vec_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int LAT_MAX = 8;
  localparam int FIELD_W = 8;

  localparam int UI_LSB       = 0;
  localparam int UIO_LSB      = 8;
  localparam int EXP_UO_LSB   = 16;
  localparam int MASK_UO_LSB  = 24;
  localparam int EXP_UIO_LSB  = 32;
  localparam int MASK_UIO_LSB = 40;

  localparam int VW_BASE = 32;
  localparam int VW_UIO  = 48;

`ifdef TT_VEC_UIO_CHECK_EN
  localparam int VW = VW_UIO;
`else
  localparam int VW = VW_BASE;
`endif

endpackage

// File: rtl/tt_vec_player_if.sv
// Host-side bus of the vector player: RAM load port, run control and result status.
interface tt_vec_player_if #(
  parameter int ADDR_W = 6,
  parameter int ERR_W  = 16,
  parameter int VW     = tt_vec_pkg::VW
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [VW-1:0]     wr_data;
  logic              start;
  logic [ADDR_W:0]   num_vec;
  logic              abort;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err;

  modport master (
    output wr_en, wr_addr, wr_data, start, num_vec, abort,
    input  busy, done, pass, err_count, first_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, num_vec, abort,
    output busy, done, pass, err_count, first_err
  );

endinterface

// File: rtl/tt_vec_delay.sv
// LAT-stage valid+data shift register; LAT=0 is a wire. Valid bits clear on reset or clr.
module tt_vec_delay #(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = clk ^ rst_n ^ clr;
      assign out_valid  = in_valid;
      assign out_data   = in_data;
    end else begin : g_pipe
      for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
        logic         v_prev;
        logic [W-1:0] d_prev;
        logic         v_reg;
        logic [W-1:0] d_reg;

        if (gi == 0) begin : g_first
          assign v_prev = in_valid;
          assign d_prev = in_data;
        end else begin : g_next
          assign v_prev = g_stage[gi-1].v_reg;
          assign d_prev = g_stage[gi-1].d_reg;
        end

        always_ff @(posedge clk) begin
          if (!rst_n || clr) begin
            v_reg <= 1'b0;
          end else begin
            v_reg <= v_prev;
          end
          d_reg <= d_prev;
        end
      end

      assign out_valid = g_stage[LAT-1].v_reg;
      assign out_data  = g_stage[LAT-1].d_reg;
    end
  endgenerate

endmodule

// File: rtl/tt_vec_player.sv
// Self-checking vector player for tt_um_* designs: plays RAM vectors, checks uo_out under mask.
// Define TT_VEC_UIO_CHECK_EN to also check uio_out where mask_uio & uio_oe.
module tt_vec_player
  import tt_vec_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int LAT    = 1,
  parameter int ERR_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  tt_vec_player_if.slave  bus,
  output logic [7:0]      ui_in,
  output logic [7:0]      uio_in,
  input  logic [7:0]      dut_uo_out,
  input  logic [7:0]      dut_uio_out,
  input  logic [7:0]      dut_uio_oe
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(LAT_MAX + 1);
`ifdef TT_VEC_UIO_CHECK_EN
  localparam int CHK_W = ADDR_W + 4 * FIELD_W;
`else
  localparam int CHK_W = ADDR_W + 2 * FIELD_W;
`endif

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0]  drain_reg, drain_next;
  logic [ADDR_W:0]   num_reg;
  logic [ERR_W-1:0]  err_reg;
  logic [ADDR_W-1:0] first_reg;

  logic [VW-1:0]     ram [DEPTH];
  logic [VW-1:0]     rd_reg;
  logic [ADDR_W-1:0] rd_addr;

  logic              start_ok, abort_ok, last_vec, can_load, running;
  logic              chk_clr, chk_valid;
  logic [CHK_W-1:0]  chk_in, chk_out;
  logic [ADDR_W-1:0] chk_idx;
  logic [7:0]        chk_exp, chk_mask;
  logic              uo_bad, uio_bad, mismatch;

  assign can_load = (state_reg == IDLE) || (state_reg == DONE);
  assign running  = (state_reg == RUN);
  assign last_vec = ({1'b0, idx_reg} == num_reg - (ADDR_W + 1)'(1));

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    drain_next = drain_reg;
    start_ok   = 1'b0;
    abort_ok   = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          start_ok   = 1'b1;
          idx_next   = '0;
          state_next = (bus.num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          abort_ok   = 1'b1;
          state_next = IDLE;
        end else if (last_vec) begin
          drain_next = '0;
          state_next = (LAT == 0) ? DONE : DRAIN;
        end else begin
          idx_next = idx_reg + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          abort_ok   = 1'b1;
          state_next = IDLE;
        end else if (drain_reg == CNT_W'(LAT - 1)) begin
          state_next = DONE;
        end else begin
          drain_next = drain_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      drain_reg <= '0;
      num_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      drain_reg <= drain_next;
      if (start_ok) begin
        num_reg <= bus.num_vec;
      end
    end
  end

  // Read runs one vector ahead so RAM[k] is on the pins during RUN cycle k.
  assign rd_addr = running ? idx_reg + ADDR_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (bus.wr_en && can_load) begin
      ram[bus.wr_addr] <= bus.wr_data;
    end
    rd_reg <= ram[rd_addr];
  end

  assign ui_in  = running ? rd_reg[UI_LSB +: FIELD_W]  : '0;
  assign uio_in = running ? rd_reg[UIO_LSB +: FIELD_W] : '0;

`ifdef TT_VEC_UIO_CHECK_EN
  assign chk_in = {rd_reg[MASK_UIO_LSB +: FIELD_W], rd_reg[EXP_UIO_LSB +: FIELD_W],
                   rd_reg[MASK_UO_LSB +: FIELD_W], rd_reg[EXP_UO_LSB +: FIELD_W], idx_reg};
`else
  assign chk_in = {rd_reg[MASK_UO_LSB +: FIELD_W], rd_reg[EXP_UO_LSB +: FIELD_W], idx_reg};
`endif

  // Flushing on start/abort keeps leftovers of an abandoned run out of the next one.
  assign chk_clr = start_ok || abort_ok;

  tt_vec_delay #(
    .W   (CHK_W),
    .LAT (LAT)
  ) u_chk_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (chk_clr),
    .in_valid  (running),
    .in_data   (chk_in),
    .out_valid (chk_valid),
    .out_data  (chk_out)
  );

  assign chk_idx  = chk_out[ADDR_W-1:0];
  assign chk_exp  = chk_out[ADDR_W +: FIELD_W];
  assign chk_mask = chk_out[ADDR_W + FIELD_W +: FIELD_W];

  always_comb begin
    uo_bad = ((dut_uo_out ^ chk_exp) & chk_mask) != '0;
`ifdef TT_VEC_UIO_CHECK_EN
    uio_bad = ((dut_uio_out ^ chk_out[ADDR_W + 2 * FIELD_W +: FIELD_W])
               & chk_out[ADDR_W + 3 * FIELD_W +: FIELD_W] & dut_uio_oe) != '0;
`else
    uio_bad = 1'b0;
`endif
    mismatch = chk_valid && (uo_bad || uio_bad);
  end

`ifndef TT_VEC_UIO_CHECK_EN
  logic unused_uio;
  assign unused_uio = ^{dut_uio_out, dut_uio_oe};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg   <= '0;
      first_reg <= '0;
    end else if (start_ok) begin
      err_reg   <= '0;
      first_reg <= '0;
    end else if (mismatch) begin
      if (err_reg == '0) begin
        first_reg <= chk_idx;
      end
      if (err_reg != '1) begin
        err_reg <= err_reg + ERR_W'(1);
      end
    end
  end

  assign bus.busy      = running || (state_reg == DRAIN);
  assign bus.done      = (state_reg == DONE);
  assign bus.pass      = (state_reg == DONE) && (err_reg == '0);
  assign bus.err_count = err_reg;
  assign bus.first_err = first_reg;

endmodule

// File: tb/tb_tt_vec_player.sv
// Directed bench for tt_vec_player against a registered loopback DUT (uo_out = ui_in delayed 1).
module tb_tt_vec_player;
  import tt_vec_pkg::*;

  localparam int ADDR_W = 6;
  localparam int LAT    = 1;
  localparam int ERR_W  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in, uio_in, dut_uo_out, dut_uio_out, dut_uio_oe;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  tt_vec_player_if #(.ADDR_W(ADDR_W), .ERR_W(ERR_W), .VW(VW)) bus ();

  tt_vec_player #(.ADDR_W(ADDR_W), .LAT(LAT), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ui_in       (ui_in),
    .uio_in      (uio_in),
    .dut_uo_out  (dut_uo_out),
    .dut_uio_out (dut_uio_out),
    .dut_uio_oe  (dut_uio_oe)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) dut_uo_out <= ui_in;
  assign dut_uio_out = 8'h00;
  assign dut_uio_oe  = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec(input logic [7:0] ui, input logic [7:0] uio,
                                        input logic [7:0] ex, input logic [7:0] mask);
    logic [VW-1:0] v;
    v = '0;
    v[UI_LSB +: FIELD_W]      = ui;
    v[UIO_LSB +: FIELD_W]     = uio;
    v[EXP_UO_LSB +: FIELD_W]  = ex;
    v[MASK_UO_LSB +: FIELD_W] = mask;
    return v;
  endfunction

  task automatic wr(input int a, input logic [VW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[ADDR_W-1:0];
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_run(input int n);
    bus.num_vec = n[ADDR_W:0];
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles from the current one, then checks results.
  task automatic finish_run(input string tag, input int exp_busy, input int exp_err,
                            input int exp_first, input int exp_pass);
    int busy_cyc;
    busy_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) break;
      if (bus.busy) busy_cyc++;
      tick();
    end
    $display("run %s: busy=%0d done=%0d pass=%0d err_count=%0d first_err=%0d",
             tag, busy_cyc, bus.done, bus.pass, bus.err_count, bus.first_err);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    chk({tag, "_err"}, 32'(bus.err_count), 32'(exp_err));
    chk({tag, "_first"}, 32'(bus.first_err), 32'(exp_first));
    chk({tag, "_pass"}, 32'(bus.pass), 32'(exp_pass));
    chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.num_vec = '0;
    bus.abort   = 1'b0;

    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_err", 32'(bus.err_count), 32'd0);
    chk("rst_ui", 32'(ui_in), 32'd0);
    rst_n = 1'b1;
    tick();

    // Four matching vectors: RUN 4 + DRAIN 1.
    wr(0, vec(8'h11, 8'hA1, 8'h11, 8'hFF));
    wr(1, vec(8'h22, 8'hA2, 8'h22, 8'hFF));
    wr(2, vec(8'h33, 8'hA3, 8'h33, 8'hFF));
    wr(3, vec(8'h44, 8'hA4, 8'h44, 8'hFF));
    start_run(4);
    chk("t1_ui0", 32'(ui_in), 32'h11);
    chk("t1_uio0", 32'(uio_in), 32'hA1);
    finish_run("t1", 5, 0, 0, 1);

    // Vector 2 drives 0x0F but expects 0xFF in the high nibble.
    wr(2, vec(8'h0F, 8'h00, 8'hFF, 8'hF0));
    start_run(4);
    finish_run("t2_mask_f0", 5, 1, 2, 0);
    wr(2, vec(8'h0F, 8'h00, 8'hFF, 8'h00));
    start_run(4);
    finish_run("t2_mask_00", 5, 0, 0, 1);

    // Empty run completes immediately.
    start_run(0);
    chk("t3_done", 32'(bus.done), 32'd1);
    chk("t3_pass", 32'(bus.pass), 32'd1);
    chk("t3_busy", 32'(bus.busy), 32'd0);
    chk("t3_ui", 32'(ui_in), 32'd0);

    // Abort at RUN cycle 3 of a 64-vector run.
    for (int i = 0; i < 64; i++) wr(i, vec(8'(i), ~8'(i), 8'(i), 8'hFF));
    start_run(64);
    tick();
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    $display("abort: busy=%0d done=%0d ui_in=0x%0h", bus.busy, bus.done, ui_in);
    chk("t4_abort_busy", 32'(bus.busy), 32'd0);
    chk("t4_abort_done", 32'(bus.done), 32'd0);
    chk("t4_abort_ui", 32'(ui_in), 32'd0);
    start_run(64);
    finish_run("t4_rerun", 65, 0, 0, 1);

    // Reset during DRAIN, then rerun from retained RAM.
    wr(1, vec(8'h01, 8'h00, 8'h81, 8'hFF));
    start_run(4);
    tick();
    tick();
    tick();
    tick();
    chk("t5_in_drain", 32'(bus.busy), 32'd1);
    chk("t5_err_before", 32'(bus.err_count), 32'd1);
    rst_n = 1'b0;
    tick();
    $display("reset: busy=%0d done=%0d err_count=%0d ui_in=0x%0h", bus.busy, bus.done,
             bus.err_count, ui_in);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_done", 32'(bus.done), 32'd0);
    chk("t5_rst_err", 32'(bus.err_count), 32'd0);
    chk("t5_rst_first", 32'(bus.first_err), 32'd0);
    chk("t5_rst_ui", 32'(ui_in), 32'd0);
    chk("t5_rst_uio", 32'(uio_in), 32'd0);
    rst_n = 1'b1;
    tick();
    start_run(4);
    finish_run("t5_rerun", 5, 1, 1, 0);

    // All 64 vectors mismatch: 2-bit counter saturates; write during RUN must be dropped.
    for (int i = 0; i < 64; i++) wr(i, vec(8'(i), 8'h00, ~8'(i), 8'hFF));
    start_run(64);
    tick();
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_addr = '0;
    bus.wr_data = vec(8'h00, 8'h00, 8'h00, 8'hFF);
    tick();
    bus.wr_en   = 1'b0;
    finish_run("t6_sat", 62, 3, 0, 0);
    start_run(1);
    finish_run("t6_ram_kept", 2, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
